// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter
//
// Round-robin AXI-Stream packet arbiter. NUM_SRC untagged sources share a
// single downstream port. Packets are framed by beat count: the effective
// packet length is latched when a source is granted, accepted beats are
// counted, m_axis_tlast is generated on the final beat, and the grant is
// released only at that packet boundary.
//
// Optional feature macro: AXIS_ARB_ZERO_BUBBLE_EN
//   undefined : every packet end passes through IDLE for one cycle.
//   defined   : on the accepted tlast beat the next winner (current source at
//               lowest priority) is granted directly, removing the idle bubble.
//
// Handshake: a beat moves on any cycle where valid and ready are both high.
// Valid never waits for ready. While a source is granted, m_axis_tvalid and
// m_axis_tdata follow that source combinationally, and that source's
// s_axis_tready follows m_axis_tready. Every other ready bit is 0.
//
// The FSM state is held in the signal 'state' (IDLE / XFER) for observation.

module axis_pkt_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int TDATA_WIDTH    = 8,
  parameter int MAX_PKT_LENGTH = 256,
  localparam int CW            = $clog2(MAX_PKT_LENGTH) + 1,
  localparam int IW            = $clog2(NUM_SRC)
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic [CW-1:0]                  pkt_length,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic [IW-1:0]                  m_axis_tid,
  output logic [CW-1:0]                  o_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IW-1:0]        grant;
  logic [IW-1:0]        grant_nxt;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        last_grant_nxt;
  logic [CW-1:0]        len;
  logic [CW-1:0]        len_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;

  logic [CW-1:0]        pkt_len_eff;
  logic [IW-1:0]        arb_base;
  logic [IW-1:0]        winner;
  logic                 winner_found;
  int                   arb_idx;

  logic                 sel_valid;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic                 in_xfer;
  logic                 last_beat;
  logic                 beat_ok;

  assign in_xfer   = (state == XFER);
  assign last_beat = (cnt == (len - CW'(1)));
  assign beat_ok   = in_xfer && sel_valid && m_axis_tready;

  // The search starts just above the source that was served most recently;
  // while a packet is in flight that is the granted source itself, which
  // places it at lowest priority for a back-to-back hand-over.
  assign arb_base = in_xfer ? grant : last_grant;

  // Normalise the requested length: 0 means a single beat, oversize clamps.
  always_comb begin
    pkt_len_eff = pkt_length;
    if (pkt_length == '0) begin
      pkt_len_eff = CW'(1);
    end else if (pkt_length > CW'(MAX_PKT_LENGTH)) begin
      pkt_len_eff = CW'(MAX_PKT_LENGTH);
    end
  end

  // Round-robin winner: first requester searching upward from arb_base+1.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    arb_idx      = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      arb_idx = (int'(arb_base) + k) % NUM_SRC;
      if (!winner_found && s_axis_tvalid[IW'(arb_idx)]) begin
        winner_found = 1'b1;
        winner       = IW'(arb_idx);
      end
    end
  end

  // Select the granted source's valid and data.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == IW'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_data  = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
      end
    end
  end

  // Route downstream ready back to the granted source only.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_axis_tready[i] = in_xfer && (grant == IW'(i)) && m_axis_tready;
    end
  end

  // Downstream outputs are quiet outside XFER.
  assign m_axis_tvalid = in_xfer && sel_valid;
  assign m_axis_tlast  = in_xfer && last_beat;
  assign m_axis_tdata  = in_xfer ? sel_data : '0;
  assign m_axis_tid    = in_xfer ? grant : '0;
  assign o_cnt         = cnt;

  // Next-state logic: grant in IDLE, count beats and release at tlast in XFER.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    len_nxt        = len;
    cnt_nxt        = cnt;
    case (state)
      IDLE: begin
        if (winner_found) begin
          state_nxt = XFER;
          grant_nxt = winner;
          len_nxt   = pkt_len_eff;
          cnt_nxt   = '0;
        end
      end
      XFER: begin
        if (beat_ok) begin
          if (last_beat) begin
            cnt_nxt        = '0;
            last_grant_nxt = grant;
`ifdef AXIS_ARB_ZERO_BUBBLE_EN
            if (winner_found) begin
              grant_nxt = winner;
              len_nxt   = pkt_len_eff;
            end else begin
              state_nxt = IDLE;
            end
`else
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      len        <= CW'(1);
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      len        <= len_nxt;
      cnt        <= cnt_nxt;
    end
  end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Round-robin AXI-Stream packet arbiter that shares one downstream stream port among NUM_SRC untagged upstream sources. Packets are framed by beat count rather than by an incoming tlast: the block latches pkt_length at grant time, counts accepted beats, generates m_axis_tlast on the final beat and releases the grant only at that packet boundary. It sits in front of the packetizing datapath and handles both the sequencing and the sharing of that datapath.

## Interface
- NUM_SRC, 4, number of upstream sources (2..16)
- TDATA_WIDTH, 8, data width per source
- MAX_PKT_LENGTH, 256, largest packet length in beats; CW = $clog2(MAX_PKT_LENGTH)+1
- aclk  in  1  clock
- resetn  in  1  reset resetn, synchronous, active-low; clock aclk
- pkt_length  in  CW  packet length in beats, sampled at grant
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tready  out  NUM_SRC  per-source ready
- s_axis_tdata  in  NUM_SRC*TDATA_WIDTH  source i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH]
- m_axis_tvalid  out  1  master valid
- m_axis_tready  in  1  master ready
- m_axis_tlast  out  1  last beat of the current packet
- m_axis_tdata  out  TDATA_WIDTH  granted source's data
- m_axis_tid  out  $clog2(NUM_SRC)  index of the granted source
- o_cnt  out  CW  beats accepted so far in the current packet

## Operation
- States: IDLE (no grant), XFER (one source granted).
- IDLE:
  - All s_axis_tready are 0; m_axis_tvalid and m_axis_tlast are 0.
  - If any s_axis_tvalid bit is set, the winner is the first requesting index found searching upward from last_grant+1, modulo NUM_SRC.
  - On the winning cycle: register grant = winner, latch len = pkt_length, cnt = 0, go to XFER.
- XFER:
  - Combinational pass-through of the granted source: m_axis_tvalid = s_axis_tvalid[grant], m_axis_tdata = that source's slice, s_axis_tready[grant] = m_axis_tready. All other ready bits are 0.
  - A beat is accepted when m_axis_tvalid & m_axis_tready; each accepted beat increments cnt.
  - m_axis_tlast = (cnt == len-1), in XFER only.
  - On an accepted beat with tlast: cnt returns to 0, last_grant = grant, state returns to IDLE.
- Length rules:
  - Latched pkt_length of 0 is treated as 1.
  - Values above MAX_PKT_LENGTH clamp to MAX_PKT_LENGTH.
  - cnt never exceeds len-1.
- No preemption and no timeout: the granted source holds the port until its tlast beat, even if its tvalid drops mid-packet.
- m_axis_tid = grant register in XFER and 0 in IDLE.
- o_cnt = cnt.

## Timing
- Reset (resetn low at a clock edge):
  - state IDLE, cnt 0, last_grant NUM_SRC-1 (source 0 is served first).
  - Outputs: m_axis_tvalid 0, m_axis_tlast 0, m_axis_tid 0, o_cnt 0, s_axis_tready all 0.
  - Reset applied mid-packet abandons the packet with no tlast emitted.
- Arbitration latency: a request seen in IDLE at cycle N is granted at the edge ending cycle N, and its first beat can transfer in cycle N+1.
- Data path latency is 0 cycles (combinational) once granted.
- Without the Configuration feature, there is a one-cycle IDLE bubble between consecutive packets.
- pkt_length changes during XFER have no effect until the next grant.
- A source whose request appears during another source's packet waits for that packet's tlast beat.

## Configuration
- Macro: AXIS_ARB_ZERO_BUBBLE_EN.
- Defined:
  - On the accepted tlast beat, the arbiter evaluates requests in the same cycle, with the current source at lowest priority.
  - If any source requests, it goes directly to XFER with the new grant, cnt 0 and a freshly latched pkt_length, so the next packet can start on the very next cycle.
  - If no source requests, it goes to IDLE.
- Undefined: every packet end passes through IDLE for one cycle.

## Test plan
- Single source, pkt_length=4, m_axis_tready=1: source 2 streams data 0xA0..0xA3 -> four beats with m_axis_tid=2, m_axis_tlast only on 0xA3, o_cnt runs 0,1,2,3, then the arbiter returns to IDLE.
- All 4 sources valid continuously, pkt_length=2 -> grants cycle 0,1,2,3,0. With the macro undefined, one idle cycle appears between packets; with AXIS_ARB_ZERO_BUBBLE_EN, there are no gaps.
- Backpressure: m_axis_tready toggles 1,0,1,0 with pkt_length=3 -> cnt advances only on handshakes, tlast is held during the stall on beat 3, and s_axis_tready of non-granted sources stays 0 throughout.
- Boundary lengths: pkt_length=0 -> a 1-beat packet with tlast on the first beat. pkt_length=MAX_PKT_LENGTH -> tlast on beat 256. pkt_length=MAX_PKT_LENGTH+5 -> clamped, tlast on beat 256.
- Mid-packet events: pkt_length changes from 4 to 8 after beat 1 -> tlast still on beat 4. Granted source drops tvalid for 3 cycles -> no regrant, and the packet completes when data resumes.
- Reset asserted after beat 2 of 5 -> next cycle has all outputs at reset values; after release, source 0 is served first with cnt 0.
